// File: rtl/lc3_trace_pkg.sv
// Shared widths, entry layout helpers and stage channel map for the LC3 trace concentrator.
package lc3_trace_pkg;

    localparam int unsigned LC3_NUM_CH = 14;

    // Channel slots in pipeline stage order; slots 8..13 are spare.
    localparam int unsigned CH_FETCH      = 0;
    localparam int unsigned CH_DECODE     = 1;
    localparam int unsigned CH_EXECUTE    = 2;
    localparam int unsigned CH_MEMACCESS  = 3;
    localparam int unsigned CH_WRITEBACK  = 4;
    localparam int unsigned CH_CONTROLLER = 5;
    localparam int unsigned CH_IMEM       = 6;
    localparam int unsigned CH_DMEM       = 7;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Entry layout, MSB to LSB: {channel, data, ts}.
    function automatic int unsigned entry_w(input int unsigned ch_bits,
                                            input int unsigned data_bits,
                                            input int unsigned ts_bits);
        return ch_bits + data_bits + ts_bits;
    endfunction

    function automatic int unsigned entry_data_lsb(input int unsigned ts_bits);
        return ts_bits;
    endfunction

    function automatic int unsigned entry_ch_lsb(input int unsigned data_bits,
                                                 input int unsigned ts_bits);
        return ts_bits + data_bits;
    endfunction

endpackage

// File: rtl/lc3_trace_arbiter_if.sv
// Producer/consumer bundle of the trace concentrator: channel inputs and drained stream.
interface lc3_trace_arbiter_if import lc3_trace_pkg::*; #(
    parameter int unsigned NUM_CH = LC3_NUM_CH,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TS_W   = 16
) ();
    localparam int unsigned CH_W  = ch_w(NUM_CH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_enable;
    logic                     clear_drops;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
    logic [DATA_W-1:0]        out_data;
    logic [TS_W-1:0]          out_ts;
    logic [CNT_W-1:0]         count;
    logic [NUM_CH-1:0]        drop_sticky;

    modport master (
        output ch_valid, ch_data, ch_enable, clear_drops, out_ready,
        input  out_valid, out_ch, out_data, out_ts, count, drop_sticky
    );

    modport slave (
        input  ch_valid, ch_data, ch_enable, clear_drops, out_ready,
        output out_valid, out_ch, out_data, out_ts, count, drop_sticky
    );
endinterface

// File: rtl/lc3_trace_fifo.sv
// Generic synchronous FIFO; push and pop in one cycle are both honoured, including at full.
module lc3_trace_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    // At full, a concurrent pop frees the slot the write pointer aliases.
    always_comb begin
        do_pop_c  = pop && (count_q != '0);
        do_push_c = push && ((count_q != CNT_W'(DEPTH)) || do_pop_c);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_c) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push_c && !do_pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/lc3_trace_arbiter.sv
// N-channel trace concentrator: per-channel holding registers, round-robin grant into an
// ordered FIFO of {channel, data, timestamp}, with sticky per-channel drop flags.
module lc3_trace_arbiter import lc3_trace_pkg::*; #(
    parameter int unsigned NUM_CH = LC3_NUM_CH,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TS_W   = 16
) (
    input logic               clock,
    input logic               reset_n,
    lc3_trace_arbiter_if.slave bus
);
    localparam int unsigned CH_W     = ch_w(NUM_CH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W  = entry_w(CH_W, DATA_W, TS_W);
    localparam int unsigned DATA_LSB = entry_data_lsb(TS_W);
    localparam int unsigned CH_LSB   = entry_ch_lsb(DATA_W, TS_W);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [NUM_CH-1:0] hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_data_q [NUM_CH];
    logic [DATA_W-1:0] hold_data_d [NUM_CH];
    logic [TS_W-1:0]   hold_ts_q   [NUM_CH];
    logic [TS_W-1:0]   hold_ts_d   [NUM_CH];
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_CH-1:0] drop_q, drop_d;

    logic [CH_W:0]      cand_c;
    logic               grant_found_c;
    logic [CH_W-1:0]    grant_idx_c;
    logic               grant_c;
    logic [NUM_CH-1:0]  grant_oh_c;
    logic [NUM_CH-1:0]  fire_c;
    logic               fifo_pop_c;
    logic [ENTRY_W-1:0] fifo_wdata_c;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    assign fire_c     = bus.ch_valid & bus.ch_enable;
    assign fifo_pop_c = !fifo_empty && bus.out_ready;

    // Round-robin search starting one past the last granted channel, with wrap.
    always_comb begin
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        cand_c        = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand_c = (CH_W + 1)'(last_grant_q) + (CH_W + 1)'(k);
            if (cand_c >= (CH_W + 1)'(NUM_CH)) begin
                cand_c = cand_c - (CH_W + 1)'(NUM_CH);
            end
            if (!grant_found_c && hold_full_q[cand_c[CH_W-1:0]]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = cand_c[CH_W-1:0];
            end
        end
    end

    always_comb begin
        grant_c    = grant_found_c && (!fifo_full || fifo_pop_c);
        grant_oh_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            grant_oh_c[i] = grant_c && (grant_idx_c == CH_W'(i));
        end
    end

    assign fifo_wdata_c = {grant_idx_c, hold_data_q[grant_idx_c], hold_ts_q[grant_idx_c]};

    // A channel being granted this cycle can recapture on the same edge.
    always_comb begin
        ts_d         = ts_q + TS_W'(1);
        hold_full_d  = hold_full_q;
        hold_data_d  = hold_data_q;
        hold_ts_d    = hold_ts_q;
        last_grant_d = last_grant_q;
        drop_d       = drop_q;
        if (grant_c) begin
            last_grant_d = grant_idx_c;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (fire_c[i] && (!hold_full_q[i] || grant_oh_c[i])) begin
                hold_full_d[i] = 1'b1;
                hold_data_d[i] = bus.ch_data[i*DATA_W +: DATA_W];
                hold_ts_d[i]   = ts_q;
            end else if (grant_oh_c[i]) begin
                hold_full_d[i] = 1'b0;
            end
            drop_d[i] = (fire_c[i] && hold_full_q[i] && !grant_oh_c[i])
                      || (drop_q[i] && !bus.clear_drops);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_q         <= '0;
            hold_full_q  <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            drop_q       <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                hold_data_q[i] <= '0;
                hold_ts_q[i]   <= '0;
            end
        end else begin
            ts_q         <= ts_d;
            hold_full_q  <= hold_full_d;
            last_grant_q <= last_grant_d;
            drop_q       <= drop_d;
            hold_data_q  <= hold_data_d;
            hold_ts_q    <= hold_ts_d;
        end
    end

    lc3_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (grant_c),
        .wdata   (fifo_wdata_c),
        .pop     (fifo_pop_c),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.out_valid   = !fifo_empty;
    assign bus.out_ch      = fifo_rdata[CH_LSB +: CH_W];
    assign bus.out_data    = fifo_rdata[DATA_LSB +: DATA_W];
    assign bus.out_ts      = fifo_rdata[TS_W-1:0];
    assign bus.count       = fifo_count;
    assign bus.drop_sticky = drop_q;

endmodule

// File: tb/tb_lc3_trace_arbiter.sv
// Directed bench for lc3_trace_arbiter: vector table for arbitration/streaming plus
// hand-written latency, backpressure, enable/clear and mid-stream reset sequences.
module tb_lc3_trace_arbiter;
    import lc3_trace_pkg::*;

    localparam int unsigned NUM_CH = 14;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TS_W   = 16;
    localparam int          NV     = 14;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    lc3_trace_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();

    lc3_trace_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [NUM_CH-1:0] valid;
        logic              ready;
        logic              clear;
        logic              exp_valid;
        logic [3:0]        exp_ch;
        logic [DATA_W-1:0] exp_data;
        logic [3:0]        exp_count;
        logic [NUM_CH-1:0] exp_drop;
    } vec_t;

    vec_t tbl [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t vec(input logic [NUM_CH-1:0] valid, input logic ev,
                                 input logic [3:0] ech, input logic [DATA_W-1:0] edata,
                                 input logic [3:0] ecnt);
        vec_t v;
        v.valid     = valid;
        v.ready     = 1'b1;
        v.clear     = 1'b0;
        v.exp_valid = ev;
        v.exp_ch    = ech;
        v.exp_data  = edata;
        v.exp_count = ecnt;
        v.exp_drop  = '0;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int ch, input logic [DATA_W-1:0] v);
        bus.ch_data[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic idle();
        bus.ch_valid    = '0;
        bus.ch_enable   = '1;
        bus.clear_drops = 1'b0;
        bus.out_ready   = 1'b1;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            set_lane(i, 16'hA000 + 16'(i));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        // Rows: inputs held for one cycle, outputs sampled just after the following edge.
        tbl[0]  = vec(14'h2021, 1'b0, 4'd0,  16'h0000, 4'd0);
        tbl[1]  = vec(14'h0000, 1'b1, 4'd0,  16'hA000, 4'd1);
        tbl[2]  = vec(14'h0000, 1'b1, 4'd5,  16'hA005, 4'd1);
        tbl[3]  = vec(14'h0000, 1'b1, 4'd13, 16'hA00D, 4'd1);
        tbl[4]  = vec(14'h2021, 1'b0, 4'd0,  16'h0000, 4'd0);
        tbl[5]  = vec(14'h0000, 1'b1, 4'd0,  16'hA000, 4'd1);
        tbl[6]  = vec(14'h0000, 1'b1, 4'd5,  16'hA005, 4'd1);
        tbl[7]  = vec(14'h0000, 1'b1, 4'd13, 16'hA00D, 4'd1);
        tbl[8]  = vec(14'h0000, 1'b0, 4'd0,  16'h0000, 4'd0);
        tbl[9]  = vec(14'h0010, 1'b0, 4'd0,  16'h0000, 4'd0);
        tbl[10] = vec(14'h0010, 1'b1, 4'd4,  16'hA004, 4'd1);
        tbl[11] = vec(14'h0010, 1'b1, 4'd4,  16'hA004, 4'd1);
        tbl[12] = vec(14'h0000, 1'b1, 4'd4,  16'hA004, 4'd1);
        tbl[13] = vec(14'h0000, 1'b0, 4'd0,  16'h0000, 4'd0);

        reset_n = 1'b0;
        idle();
        step();
        step();
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.out_ch",    32'(bus.out_ch),    32'd0);
        check("reset.out_data",  32'(bus.out_data),  32'd0);
        check("reset.out_ts",    32'(bus.out_ts),    32'd0);
        check("reset.count",     32'(bus.count),     32'd0);
        check("reset.drop",      32'(bus.drop_sticky), 32'd0);
        reset_n = 1'b1;

        // Round-robin and back-to-back per-channel streaming
        for (int r = 0; r < NV; r++) begin
            bus.ch_valid    = tbl[r].valid;
            bus.out_ready   = tbl[r].ready;
            bus.clear_drops = tbl[r].clear;
            step();
            check($sformatf("rr%0d.valid", r), 32'(bus.out_valid), 32'(tbl[r].exp_valid));
            check($sformatf("rr%0d.count", r), 32'(bus.count), 32'(tbl[r].exp_count));
            check($sformatf("rr%0d.drop", r),  32'(bus.drop_sticky), 32'(tbl[r].exp_drop));
            if (tbl[r].exp_valid) begin
                check($sformatf("rr%0d.ch", r),   32'(bus.out_ch),   32'(tbl[r].exp_ch));
                check($sformatf("rr%0d.data", r), 32'(bus.out_data), 32'(tbl[r].exp_data));
            end
        end
        idle();

        // Single event: two-cycle latency and timestamp capture
        do_reset();
        repeat (5) step();
        set_lane(3, 16'h1234);
        bus.ch_valid = 14'h0008;
        step();
        check("single.cycle1_valid", 32'(bus.out_valid), 32'd0);
        bus.ch_valid = '0;
        step();
        check("single.valid", 32'(bus.out_valid), 32'd1);
        check("single.ch",    32'(bus.out_ch),    32'd3);
        check("single.data",  32'(bus.out_data),  32'h1234);
        check("single.ts",    32'(bus.out_ts),    32'd5);
        check("single.drop",  32'(bus.drop_sticky), 32'd0);
        step();
        check("single.drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: FIFO saturates, holding register fills, then drops
        do_reset();
        bus.out_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
            set_lane(1, 16'h0100 + 16'(j));
            bus.ch_valid = 14'h0002;
            step();
        end
        bus.ch_valid = '0;
        check("bp.count_full", 32'(bus.count), 32'd8);
        check("bp.drop",       32'(bus.drop_sticky), 32'h0002);
        step();
        check("bp.count_hold", 32'(bus.count), 32'd8);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            check($sformatf("bp.e%0d.ch", j),   32'(bus.out_ch),   32'd1);
            check($sformatf("bp.e%0d.data", j), 32'(bus.out_data), 32'h0100 + 32'(j));
            check($sformatf("bp.e%0d.ts", j),   32'(bus.out_ts),   32'(j));
            step();
            if (j == 0) begin
                check("bp.full_push_pop_count", 32'(bus.count), 32'd8);
            end
        end
        check("bp.empty_valid", 32'(bus.out_valid), 32'd0);
        check("bp.empty_count", 32'(bus.count), 32'd0);

        // Disabled channel: no capture, no drop; held content still drains
        do_reset();
        bus.ch_enable[2] = 1'b0;
        bus.ch_valid     = 14'h0004;
        for (int j = 0; j < 3; j++) begin
            step();
            check($sformatf("en.off%0d.valid", j), 32'(bus.out_valid), 32'd0);
            check($sformatf("en.off%0d.drop", j),  32'(bus.drop_sticky), 32'd0);
        end
        bus.ch_valid = '0;
        step();
        check("en.off.count", 32'(bus.count), 32'd0);
        bus.ch_enable[2] = 1'b1;
        bus.ch_valid     = 14'h0004;
        step();
        bus.ch_valid     = '0;
        bus.ch_enable[2] = 1'b0;
        step();
        check("en.drain.valid", 32'(bus.out_valid), 32'd1);
        check("en.drain.ch",    32'(bus.out_ch),    32'd2);
        step();
        check("en.drain.done",  32'(bus.out_valid), 32'd0);
        bus.ch_enable[2] = 1'b1;

        // Two contending channels; clear_drops versus a same-cycle drop
        bus.ch_valid = 14'h0003;
        step();
        check("clr.c0.drop", 32'(bus.drop_sticky), 32'h0000);
        step();
        check("clr.c1.drop", 32'(bus.drop_sticky), 32'h0002);
        bus.clear_drops = 1'b1;
        step();
        check("clr.c2.drop", 32'(bus.drop_sticky), 32'h0001);
        step();
        check("clr.new_drop_wins", 32'(bus.drop_sticky), 32'h0002);
        bus.ch_valid = '0;
        step();
        check("clr.cleared", 32'(bus.drop_sticky), 32'h0000);
        bus.clear_drops = 1'b0;
        repeat (4) step();
        check("clr.drained", 32'(bus.count), 32'd0);

        // Reset with queued entries and a drop outstanding
        do_reset();
        bus.out_ready = 1'b0;
        bus.ch_valid  = 14'h03C0;
        step();
        bus.ch_valid  = 14'h0200;
        step();
        bus.ch_valid  = '0;
        repeat (3) step();
        check("rst.pre_count", 32'(bus.count), 32'd4);
        check("rst.pre_drop",  32'(bus.drop_sticky), 32'h0200);
        check("rst.pre_head",  32'(bus.out_ch), 32'd6);
        reset_n = 1'b0;
        #1;
        check("rst.async_valid", 32'(bus.out_valid), 32'd0);
        check("rst.async_count", 32'(bus.count), 32'd0);
        check("rst.async_drop",  32'(bus.drop_sticky), 32'd0);
        step();
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        bus.ch_valid  = 14'h2001;
        step();
        bus.ch_valid  = '0;
        step();
        check("rst.first_valid", 32'(bus.out_valid), 32'd1);
        check("rst.first_ch",    32'(bus.out_ch), 32'd0);
        step();
        check("rst.second_ch",   32'(bus.out_ch), 32'd13);
        step();
        check("rst.done_valid",  32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
